// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// default prescaler, which gives one decrement per second at CLOCK_50.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

  localparam int DEFAULT_PRESCALE = 50_000_000;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer. The master side (buttons,
// switches) drives Load/Value/Start/Pause; the timer returns Q and flags.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             Load;
  logic [WIDTH-1:0] Value;
  logic             Start;
  logic             Pause;
  logic [WIDTH-1:0] Q;
  logic             Running;
  logic             Tick;
  logic             Done;

  modport master (
    output Load, Value, Start, Pause,
    input  Q, Running, Tick, Done
  );

  modport slave (
    input  Load, Value, Start, Pause,
    output Q, Running, Tick, Done
  );
endinterface

// File: rtl/tick_gen.sv
// Modulo-PRESCALE cycle counter. Tick flags the last count of a period so the
// owner can decide, in the same cycle, whether that period actually completes.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic Clk,
  input  logic Clr,
  input  logic En,
  input  logic Sync,
  output logic Tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: Sync restarts the period, En advances it and wraps at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (Sync) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register, cleared asynchronously with the rest of the timer.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter. Decrements Q once per PRESCALE cycles while
// running, pulses Tick after each decrement and parks in DONE at zero.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic         Clk,
  input  logic         Clr,
  countdown_timer_if.slave bus
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic prescaleLast;
  logic prescaleEn;
  logic prescaleSync;

  // The prescaler only advances in RUN on cycles that are not paused or
  // overridden by a load, so a pause holds it exactly where it stopped.
  assign prescaleEn   = (state_q == RUN) && !bus.Load && !bus.Pause;
  assign prescaleSync = bus.Load || ((state_q == IDLE) && (state_d == RUN));

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .Clk  (Clk),
    .Clr  (Clr),
    .En   (prescaleEn),
    .Sync (prescaleSync),
    .Tick (prescaleLast)
  );

  // Next state, count and flags; Load beats Pause beats Start everywhere.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (bus.Load) begin
      count_d = bus.Value;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.Pause && bus.Start && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (bus.Pause) begin
            state_d = PAUSED;
          end else if (prescaleLast && (count_q != '0)) begin
            count_d = count_q - 1'b1;
            tick_d  = 1'b1;
            if (count_q == WIDTH'(1)) state_d = DONE;
          end
        end
        PAUSED: begin
          if (!bus.Pause && bus.Start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State and output registers; Clr drops everything to an empty IDLE.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.Q       = count_q;
  assign bus.Tick    = tick_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at PRESCALE=4, WIDTH=8: a vector table
// for the basic countdown and load behaviour, plus hand sequences for pause,
// pause-on-terminal, long countdown and asynchronous clear.
module tb_countdown_timer;

  logic Clk;
  logic Clr;
  int   checks;
  int   errors;

  countdown_timer_if #(.WIDTH(8)) bus ();

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  // 10 ns system clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       load;
    logic [7:0] value;
    logic       start;
    logic       pause;
    logic [7:0] expQ;
    logic       expRun;
    logic       expTick;
    logic       expDone;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic l, logic [7:0] v, logic s, logic p,
                              logic [7:0] q, logic r, logic t, logic d);
    vec_t x;
    x.name = n; x.load = l; x.value = v; x.start = s; x.pause = p;
    x.expQ = q; x.expRun = r; x.expTick = t; x.expDone = d;
    return x;
  endfunction

  task automatic applyStimulus(input logic l, input logic [7:0] v,
                               input logic s, input logic p);
    bus.Load  = l;
    bus.Value = v;
    bus.Start = s;
    bus.Pause = p;
  endtask

  task automatic checkVal(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic checkOutput(input string n, input logic [7:0] q, input logic r,
                             input logic t, input logic d);
    checkVal({n, ".Q"}, int'(bus.Q), int'(q));
    checkVal({n, ".Running"}, int'(bus.Running), int'(r));
    checkVal({n, ".Tick"}, int'(bus.Tick), int'(t));
    checkVal({n, ".Done"}, int'(bus.Done), int'(d));
  endtask

  // One clock edge with the given inputs, leaving us 1 ns past the edge.
  task automatic step(input logic l, input logic [7:0] v, input logic s, input logic p);
    applyStimulus(l, v, s, p);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int landing;
    int doneEdge;
    int tickCount;
    int wrapErr;
    logic [7:0] prevQ;

    checks = 0;
    errors = 0;
    Clr = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    #12;
    checkOutput("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    Clr = 1'b0;
    @(posedge Clk);
    #1;

    vecs.push_back(mk("load3",   1, 3, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("start3",  0, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk("e1",      0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("e2",      0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("e3",      0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("e4",      0, 0, 0, 0, 2, 1, 1, 0));
    vecs.push_back(mk("e5",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("e6",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("e7",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("e8",      0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("e9",      0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("e10",     0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("e11",     0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("e12",     0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("e13",     0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("doneSt",  0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("donePs",  0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("load2",   1, 2, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk("start2",  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("r1",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("r2",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("r3",      0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("load9tt", 1, 9, 1, 0, 9, 0, 0, 0));
    vecs.push_back(mk("start9",  0, 0, 1, 0, 9, 1, 0, 0));
    vecs.push_back(mk("load0",   1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("start0",  0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle0a",  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pause0",  0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].load, vecs[i].value, vecs[i].start, vecs[i].pause);
      checkOutput(vecs[i].name, vecs[i].expQ, vecs[i].expRun, vecs[i].expTick, vecs[i].expDone);
    end

    // Pause at edge 6 for 10 cycles: the decrement due at edge 8 lands at 19.
    step(1, 8'd5, 0, 0);
    step(0, 0, 1, 0);
    for (int e = 1; e <= 5; e++) step(0, 0, 0, 0);
    checkOutput("preP", 8'd4, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    checkOutput("pauseE6", 8'd4, 1'b0, 1'b0, 1'b0);
    for (int e = 7; e <= 15; e++) begin
      step(0, 0, 0, (e == 9) ? 1'b1 : 1'b0);
      checkOutput($sformatf("paused%0d", e), 8'd4, 1'b0, 1'b0, 1'b0);
    end
    step(0, 0, 1, 0);
    checkOutput("resume16", 8'd4, 1'b1, 1'b0, 1'b0);
    landing = -1;
    for (int e = 17; e <= 30; e++) begin
      step(0, 0, 0, 0);
      if (landing < 0 && bus.Q == 8'd3) begin
        landing = e;
        checkVal("landTick", int'(bus.Tick), 1);
      end
    end
    checkVal("pauseLanding", landing, 19);

    // Pause on the terminal prescaler cycle defers the decrement.
    step(1, 8'd2, 0, 0);
    step(0, 0, 1, 0);
    for (int e = 1; e <= 3; e++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checkOutput("termPause", 8'd2, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 0);
    checkOutput("termResume", 8'd2, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    checkOutput("termDec", 8'd1, 1'b1, 1'b1, 1'b0);

    // Full-scale countdown from 255: Done at edge 1020, no wrap below zero.
    step(1, 8'd255, 0, 0);
    step(0, 0, 1, 0);
    doneEdge  = -1;
    tickCount = 0;
    wrapErr   = 0;
    prevQ     = bus.Q;
    for (int e = 1; e <= 1040; e++) begin
      step(0, 0, 0, 0);
      if (bus.Tick) tickCount++;
      if (bus.Q != prevQ && bus.Q != prevQ - 8'd1) wrapErr++;
      if (bus.Q > prevQ && !(prevQ == 8'd0 && bus.Q == 8'd0)) wrapErr++;
      if (bus.Done && doneEdge < 0) doneEdge = e;
      prevQ = bus.Q;
    end
    checkVal("doneEdge255", doneEdge, 1020);
    checkVal("ticks255", tickCount, 255);
    checkVal("noWrap", wrapErr, 0);
    checkOutput("final255", 8'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous clear mid-RUN at Q=7, then Start must be ignored.
    step(1, 8'd8, 0, 0);
    step(0, 0, 1, 0);
    for (int e = 1; e <= 5; e++) step(0, 0, 0, 0);
    checkOutput("preClr", 8'd7, 1'b1, 1'b0, 1'b0);
    #2;
    Clr = 1'b1;
    #1;
    checkOutput("asyncClr", 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    Clr = 1'b0;
    step(0, 0, 1, 0);
    checkOutput("startAfterClr", 8'd0, 1'b0, 1'b0, 1'b0);
    step(1, 8'd7, 0, 0);
    step(0, 0, 1, 0);
    checkOutput("restart", 8'd7, 1'b1, 1'b0, 1'b0);

    applyStimulus(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
